// File: rtl/input_channel.sv
// rtl/input_channel.sv - per-input router stage: flit FIFO, node-table lookup, held output request
//
// One instance sits on each router input (inject/W/S/E/N). Incoming flits are
// buffered in a small FIFO. When a HEAD (or HEAD+TAIL) flit reaches the front,
// its destination id is looked up in a programmable node table. That gives the
// output port for the whole packet. req is then held to that output's mux
// controller until the packet's last flit has been popped.
//
// Ports
//   clk        clock, all state updates on posedge
//   rst_       asynchronous reset, active-high
//   in_flit    flit from upstream link
//   in_valid   in_flit is valid
//   in_ready   FIFO can accept (not full); transfer on in_valid & in_ready
//   tbl_we     node-table write strobe
//   tbl_addr   node-table entry to write
//   tbl_data   output port for that destination
//   port       output port of the current packet (latched per packet)
//   req        request to the mux controller selected by port
//   grt        grant to this input (OR over all controllers)
//   out_flit   FIFO head flit, to the crossbar
//   out_valid  out_flit is transferred this cycle
//   err        sticky: a non-head flit reached the FIFO front between packets
module input_channel #(
   parameter int DATAW    = 64,
   parameter int DSTW     = 4,
   parameter int DEPTH    = 4,
   parameter int PORTW_P1 = 3
) (
   input  logic                clk,
   input  logic                rst_,
   input  logic [DATAW-1:0]    in_flit,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic                tbl_we,
   input  logic [DSTW-1:0]     tbl_addr,
   input  logic [PORTW_P1-1:0] tbl_data,
   output logic [PORTW_P1-1:0] port,
   output logic                req,
   input  logic                grt,
   output logic [DATAW-1:0]    out_flit,
   output logic                out_valid,
   output logic                err
);

   localparam int PTRW = $clog2(DEPTH);
   localparam int CNTW = PTRW + 1;
   localparam int NENT = 2 ** DSTW;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ROUTE  = 2'd1,
      S_ACTIVE = 2'd2
   } state_t;

   state_t              state;

   // FIFO storage and bookkeeping
   logic [DATAW-1:0]    mem [DEPTH];
   logic [PTRW-1:0]     wr_ptr;
   logic [PTRW-1:0]     rd_ptr;
   logic [CNTW-1:0]     count;
   logic                empty;
   logic                full;
   logic                push;
   logic                pop;
   logic                drop;

   // Head flit fields
   logic [DATAW-1:0]    head_flit;
   logic [1:0]          head_type;
   logic [DSTW-1:0]     head_dst;

   // Node table: destination id -> output port
   logic [PORTW_P1-1:0] node_tbl [NENT];

   always_comb begin
      empty     = (count == '0);
      full      = (count == CNTW'(DEPTH));
      in_ready  = !full;
      // A full FIFO refuses a push even when a pop frees a slot on the same
      // edge; in_ready stays a pure function of registered occupancy.
      push      = in_valid && !full;
      head_flit = mem[rd_ptr];
      head_type = head_flit[DATAW-1:DATAW-2];
      head_dst  = head_flit[DATAW-3 -: DSTW];
      out_flit  = head_flit;
      // Type bit 0 marks a packet start (HEAD, HEAD+TAIL); bit 1 marks a packet end (TAIL, HEAD+TAIL).
      drop      = (state == S_IDLE) && !empty && !head_type[0];
      out_valid = (state == S_ACTIVE) && grt && !empty;
      pop       = drop || out_valid;
   end

   // FIFO data array: no reset needed, contents are qualified by count
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= in_flit;
      end
   end

   // FIFO pointers and occupancy; pointers wrap naturally (DEPTH is a power of 2)
   always_ff @(posedge clk or posedge rst_) begin
      if (rst_) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PTRW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTRW'(1);
         end
         case ({push, pop})
            2'b10:   count <= count + CNTW'(1);
            2'b01:   count <= count - CNTW'(1);
            default: count <= count;
         endcase
      end
   end

   // Node table writes land at the edge, so a lookup in the same cycle sees the old entry
   always_ff @(posedge clk or posedge rst_) begin
      if (rst_) begin
         for (int i = 0; i < NENT; i++) begin
            node_tbl[i] <= '0;
         end
      end else if (tbl_we) begin
         node_tbl[tbl_addr] <= tbl_data;
      end
   end

   // Packet state machine with registered port/req/err
   always_ff @(posedge clk or posedge rst_) begin
      if (rst_) begin
         state <= S_IDLE;
         port  <= '0;
         req   <= 1'b0;
         err   <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (!empty) begin
                  if (head_type[0]) begin
                     state <= S_ROUTE;
                  end else begin
                     // Stray BODY/TAIL between packets: popped via drop, flagged here
                     err <= 1'b1;
                  end
               end
            end
            S_ROUTE: begin
               port  <= node_tbl[head_dst];
               req   <= 1'b1;
               state <= S_ACTIVE;
            end
            S_ACTIVE: begin
               // req stays high even when the FIFO runs dry so the controller keeps its hold
               if (out_valid && head_type[1]) begin
                  req   <= 1'b0;
                  state <= S_IDLE;
               end
            end
            default: begin
               state <= S_IDLE;
               req   <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_input_channel.sv
// tb/tb_input_channel.sv - self-checking bench for input_channel
module tb_input_channel;

   localparam int DATAW = 64;
   localparam int DSTW  = 4;
   localparam int DEPTH = 4;
   localparam int PW    = 3;
   localparam int PLW   = DATAW - 2 - DSTW;

   localparam logic [1:0] T_BODY = 2'b00;
   localparam logic [1:0] T_HEAD = 2'b01;
   localparam logic [1:0] T_TAIL = 2'b10;
   localparam logic [1:0] T_HT   = 2'b11;

   logic             clk = 1'b0;
   logic             rst_ = 1'b1;
   logic [DATAW-1:0] in_flit = '0;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic             tbl_we = 1'b0;
   logic [DSTW-1:0]  tbl_addr = '0;
   logic [PW-1:0]    tbl_data = '0;
   logic [PW-1:0]    port;
   logic             req;
   logic             grt = 1'b0;
   logic [DATAW-1:0] out_flit;
   logic             out_valid;
   logic             err;

   int n_cmp = 0;
   int n_bad = 0;

   input_channel #(.DATAW(DATAW), .DSTW(DSTW), .DEPTH(DEPTH), .PORTW_P1(PW)) dut (
      .clk(clk), .rst_(rst_), .in_flit(in_flit), .in_valid(in_valid), .in_ready(in_ready),
      .tbl_we(tbl_we), .tbl_addr(tbl_addr), .tbl_data(tbl_data), .port(port), .req(req),
      .grt(grt), .out_flit(out_flit), .out_valid(out_valid), .err(err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]      typ;
      logic [DSTW-1:0] dst;
      logic [PW-1:0]   tv;
      logic            exp_req3;
      logic            exp_ov3;
      logic [PW-1:0]   exp_port3;
      logic            exp_req4;
      logic            exp_err4;
   } vec_t;

   function automatic logic [DATAW-1:0] mk(input logic [1:0] t, input logic [DSTW-1:0] d, input int seed);
      logic [63:0] r;
      r = 64'h0123_4567_89AB_CDEF ^ (64'(seed) * 64'h9E37_79B9_7F4A_7C15);
      return {t, d, r[PLW-1:0]};
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic next();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      in_valid = 1'b0;
      tbl_we   = 1'b0;
      grt      = 1'b0;
      rst_     = 1'b1;
      @(negedge clk);
      rst_ = 1'b0;
      next();
   endtask

   task automatic tbl_write(input logic [DSTW-1:0] a, input logic [PW-1:0] v);
      tbl_we   = 1'b1;
      tbl_addr = a;
      tbl_data = v;
      next();
      tbl_we   = 1'b0;
   endtask

   vec_t             vecs [6];
   logic [DATAW-1:0] f [4];
   logic [DATAW-1:0] x;
   logic [DATAW-1:0] gin [9];
   bit               gv [9];
   bit               eov [9];
   bit               ereq [9];
   logic [PW-1:0]    tbl_model [16];
   logic [DATAW-1:0] stim [$];
   logic [DATAW-1:0] expf [$];
   logic [PW-1:0]    expp [$];
   bit               any_stray;

   initial begin
      // Reset state, checked while reset is held and before any clock edge
      #2;
      chk("reset_port", 64'(port), 64'd0);
      chk("reset_req", 64'(req), 64'd0);
      chk("reset_err", 64'(err), 64'd0);
      chk("reset_out_valid", 64'(out_valid), 64'd0);
      chk("reset_in_ready", 64'(in_ready), 64'd1);

      // Single-flit vectors: push at cycle 0, grant at cycle 3
      vecs[0] = '{T_HT,   4'd5,  3'd3, 1'b1, 1'b1, 3'd3, 1'b0, 1'b0};
      vecs[1] = '{T_HT,   4'd0,  3'd4, 1'b1, 1'b1, 3'd4, 1'b0, 1'b0};
      vecs[2] = '{T_HT,   4'd15, 3'd1, 1'b1, 1'b1, 3'd1, 1'b0, 1'b0};
      vecs[3] = '{T_HEAD, 4'd9,  3'd2, 1'b1, 1'b1, 3'd2, 1'b1, 1'b0};
      vecs[4] = '{T_BODY, 4'd5,  3'd3, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1};
      vecs[5] = '{T_TAIL, 4'd7,  3'd4, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1};
      for (int i = 0; i < 6; i++) begin
         do_reset();
         tbl_write(vecs[i].dst, vecs[i].tv);
         x = mk(vecs[i].typ, vecs[i].dst, i);
         in_valid = 1'b1;
         in_flit  = x;
         next();
         in_valid = 1'b0;
         next();
         next();
         grt = 1'b1;
         @(negedge clk);
         chk($sformatf("vec%0d_req_c3", i), 64'(req), 64'(vecs[i].exp_req3));
         chk($sformatf("vec%0d_ov_c3", i), 64'(out_valid), 64'(vecs[i].exp_ov3));
         chk($sformatf("vec%0d_port_c3", i), 64'(port), 64'(vecs[i].exp_port3));
         if (vecs[i].exp_ov3) chk($sformatf("vec%0d_flit_c3", i), out_flit, x);
         next();
         grt = 1'b0;
         @(negedge clk);
         chk($sformatf("vec%0d_req_c4", i), 64'(req), 64'(vecs[i].exp_req4));
         chk($sformatf("vec%0d_ov_c4", i), 64'(out_valid), 64'd0);
         chk($sformatf("vec%0d_err_c4", i), 64'(err), 64'(vecs[i].exp_err4));
      end

      // 4-flit packet with no grant: FIFO fills, req holds; then drained back to back
      do_reset();
      tbl_write(4'd3, 3'd2);
      f[0] = mk(T_HEAD, 4'd3, 100);
      f[1] = mk(T_BODY, 4'd1, 101);
      f[2] = mk(T_BODY, 4'd2, 102);
      f[3] = mk(T_TAIL, 4'd3, 103);
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1;
         in_flit  = f[i];
         next();
      end
      in_valid = 1'b0;
      @(negedge clk);
      chk("full_in_ready_c4", 64'(in_ready), 64'd0);
      chk("full_req_c4", 64'(req), 64'd1);
      chk("full_port_c4", 64'(port), 64'd2);
      chk("full_ov_nogrt_c4", 64'(out_valid), 64'd0);
      next();
      next();
      @(negedge clk);
      chk("full_req_c6", 64'(req), 64'd1);
      next();
      grt = 1'b1;
      for (int i = 0; i < 4; i++) begin
         // Offer an extra head while full and popping: it must be refused
         in_valid = (i == 0);
         in_flit  = mk(T_HT, 4'd3, 199);
         @(negedge clk);
         chk($sformatf("drain%0d_ov", i), 64'(out_valid), 64'd1);
         chk($sformatf("drain%0d_flit", i), out_flit, f[i]);
         chk($sformatf("drain%0d_req", i), 64'(req), 64'd1);
         next();
      end
      in_valid = 1'b0;
      @(negedge clk);
      chk("drain_req_after_tail", 64'(req), 64'd0);
      chk("drain_ov_after_tail", 64'(out_valid), 64'd0);
      chk("drain_in_ready", 64'(in_ready), 64'd1);
      next();
      next();
      @(negedge clk);
      chk("full_push_refused", 64'(req), 64'd0);
      grt = 1'b0;

      // Upstream gap of 3 cycles between BODY flits, grant held
      do_reset();
      tbl_write(4'd6, 3'd1);
      f[0] = mk(T_HEAD, 4'd6, 200);
      f[1] = mk(T_BODY, 4'd0, 201);
      f[2] = mk(T_BODY, 4'd0, 202);
      f[3] = mk(T_TAIL, 4'd0, 203);
      gv   = '{1, 1, 0, 0, 0, 1, 1, 0, 0};
      eov  = '{0, 0, 0, 1, 1, 0, 1, 1, 0};
      ereq = '{0, 0, 0, 1, 1, 1, 1, 1, 0};
      gin  = '{f[0], f[1], '0, '0, '0, f[2], f[3], '0, '0};
      begin
         int k;
         k = 0;
         for (int c = 0; c < 9; c++) begin
            in_valid = gv[c];
            in_flit  = gin[c];
            grt      = 1'b1;
            @(negedge clk);
            chk($sformatf("gap_c%0d_ov", c), 64'(out_valid), 64'(eov[c]));
            chk($sformatf("gap_c%0d_req", c), 64'(req), 64'(ereq[c]));
            if (eov[c]) begin
               chk($sformatf("gap_c%0d_flit", c), out_flit, f[k]);
               k++;
            end
            next();
         end
      end
      in_valid = 1'b0;
      grt = 1'b0;

      // Stray BODY while idle is dropped and flagged; next head routes normally
      do_reset();
      tbl_write(4'd2, 3'd4);
      in_valid = 1'b1;
      in_flit  = mk(T_BODY, 4'd2, 300);
      next();
      in_valid = 1'b0;
      @(negedge clk);
      chk("stray_err_c1", 64'(err), 64'd0);
      next();
      x = mk(T_HT, 4'd2, 301);
      in_valid = 1'b1;
      in_flit  = x;
      @(negedge clk);
      chk("stray_err_c2", 64'(err), 64'd1);
      chk("stray_req_c2", 64'(req), 64'd0);
      next();
      in_valid = 1'b0;
      next();
      next();
      grt = 1'b1;
      @(negedge clk);
      chk("stray_head_req_c5", 64'(req), 64'd1);
      chk("stray_head_port_c5", 64'(port), 64'd4);
      chk("stray_head_ov_c5", 64'(out_valid), 64'd1);
      chk("stray_head_flit_c5", out_flit, x);
      next();
      grt = 1'b0;
      @(negedge clk);
      chk("stray_req_c6", 64'(req), 64'd0);
      chk("stray_err_sticky", 64'(err), 64'd1);

      // Table write during the ROUTE cycle is not seen by that packet
      do_reset();
      tbl_write(4'd5, 3'd2);
      x = mk(T_HT, 4'd5, 400);
      in_valid = 1'b1;
      in_flit  = x;
      next();
      in_valid = 1'b0;
      next();
      tbl_we   = 1'b1;
      tbl_addr = 4'd5;
      tbl_data = 3'd4;
      next();
      tbl_we = 1'b0;
      grt    = 1'b1;
      @(negedge clk);
      chk("tblrace_port_old", 64'(port), 64'd2);
      chk("tblrace_req", 64'(req), 64'd1);
      chk("tblrace_ov", 64'(out_valid), 64'd1);
      next();
      x = mk(T_HT, 4'd5, 401);
      in_valid = 1'b1;
      in_flit  = x;
      @(negedge clk);
      chk("tblrace_req_c4", 64'(req), 64'd0);
      next();
      in_valid = 1'b0;
      next();
      next();
      @(negedge clk);
      chk("tblrace_port_new", 64'(port), 64'd4);
      chk("tblrace_req2", 64'(req), 64'd1);
      chk("tblrace_flit2", out_flit, x);
      next();
      grt = 1'b0;
      @(negedge clk);
      chk("tblrace_port_kept", 64'(port), 64'd4);

      // Asynchronous reset mid-packet with flits buffered
      do_reset();
      tbl_write(4'd1, 3'd3);
      in_valid = 1'b1;
      in_flit  = mk(T_HEAD, 4'd1, 500);
      next();
      in_flit  = mk(T_BODY, 4'd1, 501);
      next();
      in_valid = 1'b0;
      next();
      grt = 1'b1;
      @(negedge clk);
      chk("rstmid_req_before", 64'(req), 64'd1);
      chk("rstmid_ov_before", 64'(out_valid), 64'd1);
      #1;
      rst_ = 1'b1;
      #1;
      chk("rstmid_req", 64'(req), 64'd0);
      chk("rstmid_in_ready", 64'(in_ready), 64'd1);
      chk("rstmid_ov", 64'(out_valid), 64'd0);
      chk("rstmid_port", 64'(port), 64'd0);
      rst_ = 1'b0;
      next();
      next();
      next();
      @(negedge clk);
      chk("rstmid_req_after", 64'(req), 64'd0);
      chk("rstmid_err_after", 64'(err), 64'd0);
      chk("rstmid_ov_after", 64'(out_valid), 64'd0);
      grt = 1'b0;

      // Randomized traffic against a packet-level reference
      do_reset();
      for (int a = 0; a < 16; a++) begin
         tbl_model[a] = PW'($urandom_range(0, 4));
         tbl_write(DSTW'(a), tbl_model[a]);
      end
      any_stray = 1'b0;
      for (int p = 0; p < 60; p++) begin
         int len;
         logic [DSTW-1:0] d;
         if (p == 0 || $urandom_range(0, 5) == 0) begin
            // Anything between packets that is not a head never reaches the output
            stim.push_back(mk($urandom_range(0, 1) ? T_TAIL : T_BODY, DSTW'($urandom_range(0, 15)), int'($urandom)));
            any_stray = 1'b1;
         end
         len = $urandom_range(1, 5);
         d   = DSTW'($urandom_range(0, 15));
         for (int j = 0; j < len; j++) begin
            logic [1:0] t;
            logic [DATAW-1:0] fl;
            t  = (len == 1) ? T_HT : (j == 0) ? T_HEAD : (j == len - 1) ? T_TAIL : T_BODY;
            fl = mk(t, (j == 0) ? d : DSTW'($urandom_range(0, 15)), int'($urandom));
            stim.push_back(fl);
            expf.push_back(fl);
            expp.push_back(tbl_model[d]);
         end
      end
      begin
         int cyc;
         cyc = 0;
         while ((stim.size() > 0 || expf.size() > 0) && cyc < 5000) begin
            in_valid = (stim.size() > 0) && ($urandom_range(0, 3) != 0);
            in_flit  = (stim.size() > 0) ? stim[0] : '0;
            grt      = ($urandom_range(0, 9) < 6);
            @(negedge clk);
            if (out_valid) begin
               chk("rand_req_with_valid", 64'(req), 64'd1);
               if (expf.size() == 0) begin
                  n_cmp++;
                  n_bad++;
                  $display("FAIL rand_extra_flit: got %0h expected no output", out_flit);
               end else begin
                  chk("rand_flit", out_flit, expf[0]);
                  chk("rand_port", 64'(port), 64'(expp[0]));
                  void'(expf.pop_front());
                  void'(expp.pop_front());
               end
            end
            if (in_valid && in_ready) void'(stim.pop_front());
            next();
            cyc++;
         end
      end
      in_valid = 1'b0;
      grt = 1'b0;
      chk("rand_drained_out", 64'(expf.size()), 64'd0);
      chk("rand_drained_in", 64'(stim.size()), 64'd0);
      chk("rand_err", 64'(err), 64'(any_stray));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
